// File: rtl/txuartfifo.sv
// Buffered UART transmitter: a 2^LGFLEN-byte FIFO drained back-to-back with runtime word/parity/stop setup.
// Define TXUFIFO_HWFLOW_EN to gate each character start on a synchronized, active-low i_cts_n.
module txuartfifo #(
    parameter int unsigned LGFLEN        = 4,
    parameter logic [29:0] INITIAL_SETUP = 30'd868
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [29:0]     i_setup,
    input  logic            i_break,
    input  logic            i_wr,
    input  logic [7:0]      i_data,
    input  logic            i_cts_n,
    output logic            o_uart_tx,
    output logic            o_busy,
    output logic            o_full,
    output logic [LGFLEN:0] o_fill,
    output logic            o_overflow
);

    localparam int unsigned      DEPTH    = 1 << LGFLEN;
    localparam logic [LGFLEN:0]  FILL_ONE = 1;
    localparam logic [LGFLEN:0]  FULL_LVL = {1'b1, {LGFLEN{1'b0}}};
    localparam logic [LGFLEN-1:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK, GUARD
    } state_t;

    state_t            state, state_n;
    logic [7:0]        fifo_mem [DEPTH];
    logic [LGFLEN-1:0] wr_ptr, rd_ptr;
    logic [LGFLEN:0]   fill_next;
    logic [7:0]        fifo_dout, masked;
    logic              push, pop, empty, gate_open, can_start;
    logic [29:0]       r_setup, cur_setup;
    logic [23:0]       baud_cnt, cpb;
    logic              baud_done;
    logic [7:0]        shreg;
    logic [2:0]        bit_cnt, nbits_m1;
    logic              parity_bit, next_parity;

    assign push      = i_wr && !o_full;
    assign empty     = (o_fill == '0);
    assign fifo_dout = fifo_mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push)
            fifo_mem[wr_ptr] <= i_data;
    end

    always_comb begin
        fill_next = o_fill;
        case ({push, pop})
            2'b10:   fill_next = o_fill + FILL_ONE;
            2'b01:   fill_next = o_fill - FILL_ONE;
            default: fill_next = o_fill;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_fill     <= '0;
            o_full     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            o_fill <= fill_next;
            o_full <= (fill_next == FULL_LVL);
            if (i_wr && o_full)
                o_overflow <= 1'b1;
        end
    end

`ifdef TXUFIFO_HWFLOW_EN
    logic [1:0] cts_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            cts_sync <= 2'b11;
        else
            cts_sync <= {cts_sync[0], i_cts_n};
    end

    assign gate_open = !cts_sync[1];
`else
    logic unused_cts;

    assign unused_cts = i_cts_n;
    assign gate_open  = 1'b1;
`endif

    // While idle the live setup is used so the character picks up the word in force at pop time.
    assign cur_setup   = (state == IDLE) ? i_setup : r_setup;
    assign cpb         = (cur_setup[23:1] == 23'd0) ? 24'd2 : cur_setup[23:0];
    assign nbits_m1    = 3'd7 - {1'b0, cur_setup[29:28]};
    assign masked      = fifo_dout & (8'hFF >> cur_setup[29:28]);
    assign next_parity = cur_setup[25] ? cur_setup[24] : ((^masked) ^ ~cur_setup[24]);
    assign baud_done   = (baud_cnt == 24'd0);
    assign can_start   = !empty && gate_open;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        if (i_break) begin
            state_n = BREAK;
        end else begin
            case (state)
                IDLE:   if (can_start) begin state_n = START; pop = 1'b1; end
                START:  if (baud_done) state_n = DATA;
                DATA:   if (baud_done && bit_cnt == 3'd0)
                            state_n = r_setup[26] ? PARITY : STOP1;
                PARITY: if (baud_done) state_n = STOP1;
                STOP1:  if (baud_done) begin
                            if (r_setup[27])   state_n = STOP2;
                            else if (can_start) begin state_n = START; pop = 1'b1; end
                            else               state_n = IDLE;
                        end
                STOP2:  if (baud_done) begin
                            if (can_start) begin state_n = START; pop = 1'b1; end
                            else           state_n = IDLE;
                        end
                BREAK:  state_n = GUARD;
                GUARD:  if (baud_done && bit_cnt == 3'd0) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // bit_cnt counts data bits during a character and the two guard periods after a break.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            r_setup    <= INITIAL_SETUP;
            baud_cnt   <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE)
                r_setup <= i_setup;
            if (state_n != state || baud_done)
                baud_cnt <= cpb - 24'd1;
            else
                baud_cnt <= baud_cnt - 24'd1;
            if (pop) begin
                shreg      <= fifo_dout;
                bit_cnt    <= nbits_m1;
                parity_bit <= next_parity;
            end else if (state == DATA && state_n == DATA && baud_done) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt - 3'd1;
            end else if (state_n == GUARD && state != GUARD) begin
                bit_cnt <= 3'd1;
            end else if (state == GUARD && state_n == GUARD && baud_done) begin
                bit_cnt <= bit_cnt - 3'd1;
            end
        end
    end

    always_comb begin
        o_uart_tx = 1'b1;
        case (state)
            START, BREAK: o_uart_tx = 1'b0;
            DATA:         o_uart_tx = shreg[0];
            PARITY:       o_uart_tx = parity_bit;
            default:      o_uart_tx = 1'b1;
        endcase
    end

    assign o_busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_txuartfifo.sv
// Scoreboard bench for txuartfifo: writes push expected frames, a line monitor decodes and compares them.
// Timing, FIFO flags, break, flow-control and reset behaviour are checked directly by the stimulus thread.
module tb_txuartfifo;

    localparam int LGFLEN  = 4;
    localparam int NORMAL  = 0;
    localparam int ABORTED = 1;
    localparam int DROPPED = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       aborted;
    } exp_t;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic [29:0]     cfg_setup = 30'd4;
    logic            i_break = 1'b0;
    logic            i_wr = 1'b0;
    logic [7:0]      i_data = 8'h00;
    logic            i_cts_n = 1'b0;
    logic            o_uart_tx, o_busy, o_full, o_overflow;
    logic [LGFLEN:0] o_fill;

    exp_t exp_q[$];
    int   start_times[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic mon_en = 1'b1;

    txuartfifo #(.LGFLEN(LGFLEN), .INITIAL_SETUP(30'd868)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_setup(cfg_setup), .i_break(i_break),
        .i_wr(i_wr), .i_data(i_data), .i_cts_n(i_cts_n), .o_uart_tx(o_uart_tx),
        .o_busy(o_busy), .o_full(o_full), .o_fill(o_fill), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // Reference frame: the low N bits, parity from the even/odd/fixed rules.
    function automatic exp_t model(input logic [7:0] b, input logic [29:0] s, input bit aborted);
        exp_t e;
        int   n, ones;
        n = 8 - int'(s[29:28]);
        e.data = 8'h00;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            e.data[i] = b[i];
            if (b[i]) ones++;
        end
        if (s[25])      e.par = s[24];
        else if (s[24]) e.par = (ones % 2 == 1);
        else            e.par = (ones % 2 == 0);
        e.aborted = aborted;
        return e;
    endfunction

    task automatic applyStimulus(input logic [7:0] b, input int mode);
        i_wr   = 1'b1;
        i_data = b;
        if (mode != DROPPED)
            exp_q.push_back(model(b, cfg_setup, mode == ABORTED));
        @(negedge i_clk);
        i_wr = 1'b0;
    endtask

    task automatic waitLineLow(output int n, input int limit);
        n = 0;
        while (o_uart_tx !== 1'b0 && n < limit) begin
            @(negedge i_clk);
            n++;
        end
        if (o_uart_tx !== 1'b0)
            checkOutput("start_bit_timeout", o_uart_tx, 0);
    endtask

    task automatic waitDrain(input string name, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge i_clk);
            n++;
        end
        checkOutput(name, exp_q.size(), 0);
        repeat (10) @(negedge i_clk);
    endtask

    initial begin : monitor
        logic       prev, s0, p, s1, s2;
        logic [7:0] rx;
        int         n, cpb, w;
        exp_t       e;
        prev = 1'b1;
        forever begin
            @(negedge i_clk);
            if (mon_en && prev === 1'b1 && o_uart_tx === 1'b0) begin
                start_times.push_back(cyc);
                n   = 8 - int'(cfg_setup[29:28]);
                cpb = int'(cfg_setup[23:0]);
                repeat (cpb / 2) @(negedge i_clk);
                s0 = o_uart_tx;
                rx = 8'h00;
                for (int i = 0; i < n; i++) begin
                    repeat (cpb) @(negedge i_clk);
                    rx[i] = o_uart_tx;
                end
                p = 1'b0;
                if (cfg_setup[26]) begin
                    repeat (cpb) @(negedge i_clk);
                    p = o_uart_tx;
                end
                repeat (cpb) @(negedge i_clk);
                s1 = o_uart_tx;
                s2 = 1'b1;
                if (cfg_setup[27]) begin
                    repeat (cpb) @(negedge i_clk);
                    s2 = o_uart_tx;
                end
                checkOutput("start_bit", s0, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_frame: actual %0h required none", rx);
                end else begin
                    e = exp_q.pop_front();
                    if (e.aborted) begin
                        checkOutput("abort_stop_low", s1, 0);
                    end else begin
                        checkOutput("frame_data", rx, e.data);
                        if (cfg_setup[26]) checkOutput("frame_parity", p, e.par);
                        checkOutput("frame_stop1", s1, 1);
                        if (cfg_setup[27]) checkOutput("frame_stop2", s2, 1);
                    end
                end
                w = 0;
                while (o_uart_tx !== 1'b1 && w < 200) begin
                    @(negedge i_clk);
                    w++;
                end
                if (o_uart_tx !== 1'b1)
                    checkOutput("line_release", o_uart_tx, 1);
            end
            prev = o_uart_tx;
        end
    end

    initial begin : watchdog
        #1000000;
        n_checks++;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int n, lows, highs, base, act;
        repeat (3) @(negedge i_clk);
        checkOutput("reset_tx", o_uart_tx, 1);
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_full", o_full, 0);
        checkOutput("reset_fill", o_fill, 0);
        checkOutput("reset_overflow", o_overflow, 0);
        i_reset = 1'b0;
        repeat (4) @(negedge i_clk);

        // 8N1 at 4 clocks/baud, 0x48: latency and frame length
        applyStimulus(8'h48, NORMAL);
        checkOutput("lat_fill_rise", o_fill, 1);
        checkOutput("lat_busy_rise", o_busy, 1);
        checkOutput("lat_tx_still_high", o_uart_tx, 1);
        @(negedge i_clk);
        checkOutput("lat_start_fall", o_uart_tx, 0);
        checkOutput("lat_fill_pop", o_fill, 0);
        repeat (39) @(negedge i_clk);
        checkOutput("frame_busy_end", o_busy, 1);
        @(negedge i_clk);
        checkOutput("frame_busy_low", o_busy, 0);
        checkOutput("frame_line_idle", o_uart_tx, 1);
        waitDrain("drain_8n1", 100);

        // Break holds the line; fill the FIFO and overrun it by one
        mon_en  = 1'b0;
        i_break = 1'b1;
        @(negedge i_clk);
        for (int i = 0; i < 17; i++)
            applyStimulus(8'h10 + 8'(i * 7), (i < 16) ? NORMAL : DROPPED);
        checkOutput("burst_fill", o_fill, 16);
        checkOutput("burst_full", o_full, 1);
        checkOutput("burst_overflow", o_overflow, 1);
        checkOutput("burst_break_line", o_uart_tx, 0);
        base    = start_times.size();
        i_break = 1'b0;
        mon_en  = 1'b1;
        waitDrain("drain_burst", 16 * 40 + 200);
        checkOutput("burst_frame_count", start_times.size() - base, 16);
        for (int i = 1; i < 16; i++)
            if (base + i < start_times.size())
                checkOutput("burst_period", start_times[base + i] - start_times[base + i - 1], 40);

        // 7E2, mark parity 8-bit, and 5O1 at 3 clocks/baud
        cfg_setup = {2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 24'd4};
        @(negedge i_clk);
        applyStimulus(8'h03, NORMAL);
        applyStimulus(8'h07, NORMAL);
        waitDrain("drain_7e2", 300);
        cfg_setup = {2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 24'd4};
        @(negedge i_clk);
        applyStimulus(8'h00, NORMAL);
        waitDrain("drain_mark", 200);
        cfg_setup = {2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 24'd3};
        @(negedge i_clk);
        applyStimulus(8'hFF, NORMAL);
        applyStimulus(8'hE6, NORMAL);
        waitDrain("drain_5o1", 200);
        checkOutput("overflow_sticky", o_overflow, 1);

        // Break during data bit 3, then the next queued byte follows the guard time
        cfg_setup = 30'd4;
        @(negedge i_clk);
        applyStimulus(8'hA5, ABORTED);
        waitLineLow(n, 20);
        applyStimulus(8'h3C, NORMAL);
        repeat (16) @(negedge i_clk);
        i_break = 1'b1;
        @(negedge i_clk);
        checkOutput("break_immediate", o_uart_tx, 0);
        lows = 0;
        repeat (23) begin
            @(negedge i_clk);
            if (o_uart_tx === 1'b0) lows++;
        end
        checkOutput("break_hold", lows, 23);
        checkOutput("break_fifo_kept", o_fill, 1);
        i_break = 1'b0;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_uart_tx !== 1'b1) break;
            highs++;
        end
        // Two guard baud periods plus the IDLE pop cycle
        checkOutput("guard_high_cycles", highs, 9);
        waitDrain("drain_break", 200);

`ifdef TXUFIFO_HWFLOW_EN
        i_cts_n = 1'b1;
        repeat (4) @(negedge i_clk);
        applyStimulus(8'h11, NORMAL);
        applyStimulus(8'h22, NORMAL);
        highs = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_uart_tx === 1'b1) highs++;
        end
        checkOutput("cts_blocked", highs, 20);
        checkOutput("cts_fill", o_fill, 2);
        i_cts_n = 1'b0;
        waitLineLow(n, 10);
        checkOutput("cts_start_latency", (n >= 1 && n <= 3), 1);
        repeat (10) @(negedge i_clk);
        i_cts_n = 1'b1;
        repeat (40) @(negedge i_clk);
        highs = 0;
        repeat (30) begin
            @(negedge i_clk);
            if (o_uart_tx === 1'b1) highs++;
        end
        checkOutput("cts_second_waits", highs, 30);
        checkOutput("cts_second_queued", o_fill, 1);
        i_cts_n = 1'b0;
        waitDrain("drain_cts", 200);
`else
        i_cts_n = 1'b1;
        applyStimulus(8'h5A, NORMAL);
        waitLineLow(n, 10);
        checkOutput("cts_ignored_start", n, 1);
        waitDrain("drain_cts_ignored", 200);
        i_cts_n = 1'b0;
`endif

        // Reset during the stop bit with 3 bytes still queued
        applyStimulus(8'h81, NORMAL);
        waitLineLow(n, 10);
        applyStimulus(8'h42, DROPPED);
        applyStimulus(8'h24, DROPPED);
        applyStimulus(8'h18, DROPPED);
        repeat (34) @(negedge i_clk);
        checkOutput("pre_reset_fill", o_fill, 3);
        i_reset = 1'b1;
        #1;
        checkOutput("midreset_tx", o_uart_tx, 1);
        checkOutput("midreset_fill", o_fill, 0);
        checkOutput("midreset_busy", o_busy, 0);
        checkOutput("midreset_overflow", o_overflow, 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        act = 0;
        repeat (80) begin
            @(negedge i_clk);
            if (o_uart_tx !== 1'b1 || o_busy !== 1'b0) act++;
        end
        checkOutput("post_reset_quiet", act, 0);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
